// File: rtl/nios_system_checkers_nios2_qsys_0_oci_dct_packer_if.sv
// DCT packer handshake bundle: atom input stream, frame output stream and test-end status.
// The master modport is the packer; the slave modport is the trace core / consumer side.
interface nios_system_checkers_nios2_qsys_0_oci_dct_packer_if #(
    parameter int ATOM_W = 2,
    parameter int DEPTH  = 15,
    parameter int CNT_W  = 4,
    parameter int FCNT_W = 16
);
    logic                      atom_valid;
    logic [ATOM_W-1:0]         atom_data;
    logic                      atom_ready;
    logic                      test_ending;
    logic                      frame_valid;
    logic                      frame_ready;
    logic [ATOM_W*DEPTH-1:0]   dct_buffer;
    logic [CNT_W-1:0]          dct_count;
    logic                      test_has_ended;
    logic [FCNT_W-1:0]         frames_sent;

    modport master (
        input  atom_valid, atom_data, test_ending, frame_ready,
        output atom_ready, frame_valid, dct_buffer, dct_count, test_has_ended, frames_sent
    );

    modport slave (
        output atom_valid, atom_data, test_ending, frame_ready,
        input  atom_ready, frame_valid, dct_buffer, dct_count, test_has_ended, frames_sent
    );
endinterface

// File: rtl/nios_system_checkers_nios2_qsys_0_oci_dct_packer.sv
// Packs trace atoms into DCT frames behind a one-deep output slot; a test-end
// flush drains the partial frame, then reports completion.
module nios_system_checkers_nios2_qsys_0_oci_dct_packer #(
    parameter int ATOM_W = 2,
    parameter int DEPTH  = 15,
    parameter int CNT_W  = 4,
    parameter int FCNT_W = 16
) (
    input  logic clk,
    input  logic reset_n,
    nios_system_checkers_nios2_qsys_0_oci_dct_packer_if.master bus
);
    localparam int BUF_W = ATOM_W * DEPTH;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_ENDED = 2'd2;

    logic [1:0]        r_state;
    logic [BUF_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_fv;
    logic [BUF_W-1:0]  r_buf;
    logic [CNT_W-1:0]  r_dcnt;
    logic [FCNT_W-1:0] r_sent;

    logic              w_full;
    logic              w_ready;
    logic              w_accept;
    logic              w_hand;
    logic              w_launch;
    logic [BUF_W-1:0]  w_acc_nxt;

    assign w_full   = (r_cnt == CNT_W'(DEPTH));
    // Gated by reset_n so atom_ready reads 0 while reset is held, like every other output.
    assign w_ready  = reset_n && (r_state == ST_RUN) && (r_cnt < CNT_W'(DEPTH));
    assign w_accept = bus.atom_valid && w_ready;
    assign w_hand   = r_fv && bus.frame_ready;
    assign w_launch = (w_full || (r_state == ST_FLUSH && r_cnt != '0)) && (!r_fv || bus.frame_ready);

    always_comb begin
        w_acc_nxt = r_acc;
        for (int k = 0; k < DEPTH; k++) begin
            if (r_cnt == CNT_W'(k)) w_acc_nxt[k*ATOM_W +: ATOM_W] = bus.atom_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_RUN;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_fv    <= 1'b0;
            r_buf   <= '0;
            r_dcnt  <= '0;
            r_sent  <= '0;
        end else begin
            // Launch only happens when no atom can be accepted, so the two never collide.
            if (w_launch) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (w_accept) begin
                r_acc <= w_acc_nxt;
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_launch) begin
                r_fv   <= 1'b1;
                r_buf  <= r_acc;
                r_dcnt <= r_cnt;
            end else if (w_hand) begin
                r_fv   <= 1'b0;
                r_buf  <= '0;
                r_dcnt <= '0;
            end

            if (w_hand) r_sent <= r_sent + 1'b1;

            case (r_state)
                ST_RUN:   if (bus.test_ending) r_state <= ST_FLUSH;
                ST_FLUSH: if (r_cnt == '0 && !r_fv) r_state <= ST_ENDED;
                ST_ENDED: r_state <= ST_ENDED;
                default:  r_state <= ST_RUN;
            endcase
        end
    end

    assign bus.atom_ready     = w_ready;
    assign bus.frame_valid    = r_fv;
    assign bus.dct_buffer     = r_buf;
    assign bus.dct_count      = r_dcnt;
    assign bus.test_has_ended = (r_state == ST_ENDED);
    assign bus.frames_sent    = r_sent;
endmodule

// File: tb/tb_nios_system_checkers_nios2_qsys_0_oci_dct_packer.sv
// Directed scenarios plus random traffic, checked every cycle against a queue-based frame model.
module tb_nios_system_checkers_nios2_qsys_0_oci_dct_packer;
    localparam int ATOM_W = 2, DEPTH = 15, CNT_W = 4, FCNT_W = 16;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    nios_system_checkers_nios2_qsys_0_oci_dct_packer_if #(
        .ATOM_W(ATOM_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .FCNT_W(FCNT_W)) bus();

    nios_system_checkers_nios2_qsys_0_oci_dct_packer #(
        .ATOM_W(ATOM_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .FCNT_W(FCNT_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pending atoms, one output slot, run/flush/ended mode.
    logic [1:0]  m_pend[$];
    bit          m_sv;
    logic [29:0] m_buf;
    logic [3:0]  m_cnt;
    int          m_mode;
    logic [15:0] m_sent;

    typedef struct packed {logic [3:0] c; logic [29:0] b;} frm_t;
    frm_t flog[$];

    always @(negedge clk) begin
        bit exp_rdy, take, hand, launch;
        int nmode;
        if (!reset_n) begin
            m_pend.delete(); m_sv = 0; m_buf = '0; m_cnt = '0; m_mode = 0; m_sent = '0;
        end
        exp_rdy = reset_n && m_mode == 0 && m_pend.size() < DEPTH;
        chk("atom_ready",     64'(bus.atom_ready),     64'(exp_rdy));
        chk("frame_valid",    64'(bus.frame_valid),    64'(m_sv));
        chk("dct_buffer",     64'(bus.dct_buffer),     64'(m_buf));
        chk("dct_count",      64'(bus.dct_count),      64'(m_cnt));
        chk("test_has_ended", 64'(bus.test_has_ended), 64'(m_mode == 2));
        chk("frames_sent",    64'(bus.frames_sent),    64'(m_sent));
        if (reset_n) begin
            if (bus.frame_valid && bus.frame_ready) flog.push_back({bus.dct_count, bus.dct_buffer});
            take   = bus.atom_valid && exp_rdy;
            hand   = m_sv && bus.frame_ready;
            launch = (m_pend.size() == DEPTH || (m_mode == 1 && m_pend.size() != 0)) &&
                     (!m_sv || bus.frame_ready);
            nmode = m_mode;
            if (m_mode == 0 && bus.test_ending) nmode = 1;
            else if (m_mode == 1 && m_pend.size() == 0 && !m_sv) nmode = 2;
            if (hand) m_sent = m_sent + 16'd1;
            if (launch) begin
                m_buf = '0;
                foreach (m_pend[k]) m_buf |= 30'(m_pend[k]) << (2 * k);
                m_cnt = 4'(m_pend.size());
                m_sv  = 1;
                m_pend.delete();
            end else if (hand) begin
                m_sv = 0; m_buf = '0; m_cnt = '0;
            end
            if (take) m_pend.push_back(bus.atom_data);
            m_mode = nmode;
        end
    end

    task automatic drive(input logic v, input logic [1:0] d, input logic te, input logic fr);
        bus.atom_valid  = v;
        bus.atom_data   = d;
        bus.test_ending = te;
        bus.frame_ready = fr;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus.atom_valid = 0; bus.atom_data = '0; bus.test_ending = 0; bus.frame_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        flog.delete();
    endtask

    initial begin
        int sum;
        reset_n = 1'b0;
        bus.atom_valid = 0; bus.atom_data = '0; bus.test_ending = 0; bus.frame_ready = 0;
        #2;
        chk("rst_atom_ready",  64'(bus.atom_ready),  64'd0);
        chk("rst_frame_valid", 64'(bus.frame_valid), 64'd0);
        do_reset();
        #3;
        chk("post_rst_ready", 64'(bus.atom_ready), 64'd1);
        @(posedge clk); #1;

        // Full frame of 2'b11
        for (int i = 0; i < 15; i++) drive(1, 2'b11, 0, 1);
        repeat (4) drive(0, 2'b00, 0, 1);
        chk("s2_nframes", 64'(flog.size()), 64'd1);
        if (flog.size() >= 1) chk("s2_frame", 64'(flog[0]), 64'({4'd15, 30'h3FFFFFFF}));
        chk("s2_sent", 64'(bus.frames_sent), 64'd1);

        // Short frame flushed at test end
        do_reset();
        drive(1, 2'd1, 0, 1); drive(1, 2'd2, 0, 1); drive(1, 2'd3, 0, 1);
        drive(0, 2'd0, 1, 1);
        repeat (6) drive(0, 2'd0, 0, 1);
        chk("s3_nframes", 64'(flog.size()), 64'd1);
        if (flog.size() >= 1) chk("s3_frame", 64'(flog[0]), 64'({4'd3, 30'h39}));
        chk("s3_ended", 64'(bus.test_has_ended), 64'd1);
        chk("s3_ready", 64'(bus.atom_ready), 64'd0);

        // Back-pressure: two frames queue up, then drain in order
        do_reset();
        for (int i = 0; i < 40; i++) drive(1, 2'($urandom), 0, 0);
        chk("s4_ready_drop", 64'(bus.atom_ready), 64'd0);
        repeat (6) drive(0, 2'd0, 0, 1);
        chk("s4_nframes", 64'(flog.size()), 64'd2);
        chk("s4_sent", 64'(bus.frames_sent), 64'd2);
        sum = 0;
        foreach (flog[i]) sum += flog[i].c;
        chk("s4_atoms", 64'(sum), 64'd30);

        // Empty flush: ended exactly two cycles after test_ending
        do_reset();
        drive(0, 2'd0, 1, 1);
        chk("s5_ended_t1", 64'(bus.test_has_ended), 64'd0);
        drive(0, 2'd0, 0, 1);
        chk("s5_ended_t2", 64'(bus.test_has_ended), 64'd1);
        chk("s5_nframes", 64'(flog.size()), 64'd0);

        // 15th atom shares the cycle with test_ending
        do_reset();
        for (int i = 0; i < 14; i++) drive(1, 2'($urandom), 0, 1);
        drive(1, 2'd2, 1, 1);
        repeat (6) drive(0, 2'd0, 0, 1);
        chk("s6_nframes", 64'(flog.size()), 64'd1);
        if (flog.size() >= 1) chk("s6_count", 64'(flog[0].c), 64'd15);
        chk("s6_ended", 64'(bus.test_has_ended), 64'd1);

        // Reset mid-frame drops the partial frame
        do_reset();
        for (int i = 0; i < 7; i++) drive(1, 2'($urandom), 0, 1);
        do_reset();
        for (int i = 0; i < 15; i++) drive(1, 2'($urandom), 0, 1);
        repeat (4) drive(0, 2'd0, 0, 1);
        chk("s7_nframes", 64'(flog.size()), 64'd1);
        if (flog.size() >= 1) chk("s7_count", 64'(flog[0].c), 64'd15);

        // Random traffic with occasional flushes and resets
        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int i = 0; i < 250; i++)
                drive($urandom_range(0, 3) != 0, 2'($urandom),
                      $urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
